scale_scheduler: RTL and testbench

SCALE_SCHEDULER -- requirements
Module: scale_scheduler

---
 rtl/scale_pkg.sv | 25 ++
 rtl/fb_wr_mux.sv | 29 ++
 rtl/scale_scheduler.sv | 174 +++++++++++++++++
 tb/tb_scale_scheduler.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared definitions for the scale scheduler: FSM states, engine mode codes and framebuffer geometry.
package scale_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned FB_W   = 640;
    localparam int unsigned FB_H   = 480;

    localparam logic [1:0] MODE_REPLICATE = 2'd0;
    localparam logic [1:0] MODE_DECIMATE  = 2'd1;
    localparam logic [1:0] MODE_NEAREST   = 2'd2;
    localparam logic [1:0] MODE_BLOCKAVG  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        RUN,
        FINISH
    } state_t;

    function automatic logic [3:0] eng_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/fb_wr_mux.sv
// Selects one engine's framebuffer write port and registers it once; writes count only while en is high.
module fb_wr_mux #(
    parameter int unsigned ADDR_W = scale_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            sel,
    input  logic [4*ADDR_W-1:0]   eng_wraddr,
    input  logic [31:0]           eng_wrdata,
    input  logic [3:0]            eng_wren,
    output logic [ADDR_W-1:0]     wraddr,
    output logic [7:0]            wrdata,
    output logic                  wren
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wraddr <= '0;
            wrdata <= '0;
            wren   <= 1'b0;
        end else begin
            wraddr <= eng_wraddr[int'(sel)*ADDR_W +: ADDR_W];
            wrdata <= eng_wrdata[int'(sel)*8 +: 8];
            wren   <= en && eng_wren[sel];
        end
    end

endmodule

// File: rtl/scale_scheduler.sv
// Runs one scaling engine per command and owns the single framebuffer write port.
// Optional pre-run framebuffer fill is compiled in with SCALE_SCHED_CLEAR_EN.
module scale_scheduler #(
    parameter int unsigned ADDR_W      = scale_pkg::ADDR_W,
    parameter int unsigned FB_DEPTH    = 307200,
    parameter logic [7:0]  BG_PIXEL    = 8'h00,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic                  cmd_zoom,
    output logic [3:0]            eng_rst,
    output logic                  eng_zoom,
    input  logic [3:0]            eng_done,
    input  logic [4*ADDR_W-1:0]   eng_wraddr,
    input  logic [31:0]           eng_wrdata,
    input  logic [3:0]            eng_wren,
    output logic [ADDR_W-1:0]     ram_wraddr,
    output logic [7:0]            ram_data,
    output logic                  ram_wren,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            cur_mode,
    output scale_pkg::state_t     fsm_state
);
    import scale_pkg::*;

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   run_cnt_q;
    logic [1:0]        mode_q;
    logic              zoom_q;
    logic              err_q;
    logic [3:0]        eng_rst_q;
    logic              accept;
    logic              run_first;
    logic              sel_done;
    logic              timeout;
    logic [ADDR_W-1:0] mux_addr;
    logic [7:0]        mux_data;
    logic              mux_wren;

    // Command handshake: a command transfers on a clk edge where cmd_valid and cmd_ready are both 1;
    // cmd_ready is 1 only in IDLE, so a request made while busy waits (is not dropped) until IDLE.
    assign accept    = cmd_valid && (state_q == IDLE);
    assign run_first = (run_cnt_q == '0);
    assign sel_done  = eng_done[mode_q];
    assign timeout   = (state_q == RUN) && !(sel_done && !run_first)
                       && (run_cnt_q == TO_W'(TIMEOUT_CYC - 1));

`ifdef SCALE_SCHED_CLEAR_EN
    localparam int unsigned CLR_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;

    logic [CLR_W-1:0] clr_cnt_q;
    logic             clr_last;

    assign clr_last = (clr_cnt_q == CLR_W'(FB_DEPTH - 1));

    // The fill address parks on the last pixel instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else if (accept) begin
            clr_cnt_q <= '0;
        end else if ((state_q == CLEAR) && !clr_last) begin
            clr_cnt_q <= clr_cnt_q + CLR_W'(1);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef SCALE_SCHED_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = LAUNCH;
`endif
                end
            end
`ifdef SCALE_SCHED_CLEAR_EN
            CLEAR:   if (clr_last) state_d = LAUNCH;
`endif
            LAUNCH:  state_d = RUN;
            RUN: begin
                if (sel_done && !run_first) begin
                    state_d = FINISH;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // eng_rst is registered so it is high exactly while the FSM sits in LAUNCH, and for the
    // first IDLE cycle after a watchdog abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            zoom_q    <= 1'b0;
            err_q     <= 1'b0;
            eng_rst_q <= 4'b1111;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            eng_rst_q <= 4'b0000;
            if (accept) begin
                mode_q <= cmd_mode;
                zoom_q <= cmd_zoom;
                err_q  <= 1'b0;
            end
            if (state_d == LAUNCH) begin
                eng_rst_q <= eng_onehot(accept ? cmd_mode : mode_q);
            end
            if (timeout) begin
                err_q     <= 1'b1;
                eng_rst_q <= eng_onehot(mode_q);
            end
            if (state_q == RUN) begin
                run_cnt_q <= run_cnt_q + TO_W'(1);
            end else begin
                run_cnt_q <= '0;
            end
        end
    end

    fb_wr_mux #(
        .ADDR_W(ADDR_W)
    ) u_fb_wr_mux (
        .clk        (clk),
        .reset      (reset),
        .en         (state_q == RUN),
        .sel        (mode_q),
        .eng_wraddr (eng_wraddr),
        .eng_wrdata (eng_wrdata),
        .eng_wren   (eng_wren),
        .wraddr     (mux_addr),
        .wrdata     (mux_data),
        .wren       (mux_wren)
    );

    always_comb begin
        cmd_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        done       = (state_q == FINISH);
        ram_wraddr = mux_addr;
        ram_data   = mux_data;
        ram_wren   = (state_q == RUN) && mux_wren;
`ifdef SCALE_SCHED_CLEAR_EN
        if (state_q == CLEAR) begin
            ram_wraddr = ADDR_W'(clr_cnt_q);
            ram_data   = BG_PIXEL;
            ram_wren   = 1'b1;
        end
`endif
    end

    assign eng_rst   = eng_rst_q;
    assign eng_zoom  = zoom_q;
    assign err       = err_q;
    assign cur_mode  = mode_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_scale_scheduler.sv
// Self-checking bench for scale_scheduler: randomized engine traffic against an expected RAM-write queue.
module tb_scale_scheduler;
    import scale_pkg::*;

    localparam int         AW    = 19;
    localparam int         DEPTH = 64;
    localparam logic [7:0] BG    = 8'h5A;
    localparam int         TMO   = 100;
    localparam int         W     = AW + 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic             cmd_zoom;
    logic [3:0]       eng_rst;
    logic             eng_zoom;
    logic [3:0]       eng_done;
    logic [4*AW-1:0]  eng_wraddr;
    logic [31:0]      eng_wrdata;
    logic [3:0]       eng_wren;
    logic [AW-1:0]    ram_wraddr;
    logic [7:0]       ram_data;
    logic             ram_wren;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       cur_mode;
    state_t           fsm_state;

    int               n_checks  = 0;
    int               n_fail    = 0;
    int               done_seen = 0;
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     mon_exp;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 50000 cycles");
        $fatal(1, "global timeout");
    end

    scale_scheduler #(
        .ADDR_W      (AW),
        .FB_DEPTH    (DEPTH),
        .BG_PIXEL    (BG),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_zoom   (cmd_zoom),
        .eng_rst    (eng_rst),
        .eng_zoom   (eng_zoom),
        .eng_done   (eng_done),
        .eng_wraddr (eng_wraddr),
        .eng_wrdata (eng_wrdata),
        .eng_wren   (eng_wren),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_mode   (cur_mode),
        .fsm_state  (fsm_state)
    );

    // scoreboard: every RAM write must be the next expected {addr,data}
    always @(negedge clk) begin
        if (done) done_seen++;
        if (ram_wren) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ram_write_unexpected: got addr=%0d data=%02h, required no write",
                         ram_wraddr, ram_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ram_wraddr, ram_data} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             ram_wraddr, ram_data, mon_exp[W-1:8], mon_exp[7:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_engines();
        eng_wren   = 4'b0000;
        eng_done   = 4'b0000;
        eng_wraddr = '0;
        eng_wrdata = '0;
    endtask

    task automatic drive_noise(input logic [1:0] sel);
        for (int k = 0; k < 4; k++) begin
            if (k != int'(sel)) begin
                eng_wren[k]             = 1'($urandom_range(0, 1));
                eng_done[k]             = 1'($urandom_range(0, 1));
                eng_wraddr[k*AW +: AW]  = AW'($urandom);
                eng_wrdata[k*8 +: 8]    = 8'($urandom);
            end
        end
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic zoom);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_zoom  = zoom;
        for (int i = 0; i < 500; i++) begin
            if (cmd_ready === 1'b1) break;
            tick();
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept_wait: cmd_ready=%b, required 1 within 500 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge; returns in the LAUNCH cycle.
    task automatic after_accept(input logic [1:0] mode, input logic zoom);
        logic [3:0] oh;
        oh = 4'b0001 << mode;
`ifdef SCALE_SCHED_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), BG});
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (busy !== 1'b1 || ram_wren !== 1'b1 || fsm_state !== CLEAR) begin
                n_fail++;
                $display("FAIL clear_cycle %0d: busy=%b wren=%b state=%0d, required busy=1 wren=1 CLEAR",
                         i, busy, ram_wren, fsm_state);
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_count: %0d fill writes outstanding, required 0", exp_q.size());
        end
`endif
        n_checks++;
        if (fsm_state !== LAUNCH || eng_rst !== oh || ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL launch: state=%0d eng_rst=%b wren=%b, required LAUNCH eng_rst=%b wren=0",
                     fsm_state, eng_rst, ram_wren, oh);
        end
        n_checks++;
        if (cur_mode !== mode || eng_zoom !== zoom || err !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL launch_status: mode=%0d zoom=%b err=%b busy=%b ready=%b, required %0d %b 0 1 0",
                     cur_mode, eng_zoom, err, busy, cmd_ready, mode, zoom);
        end
    endtask

    // Starts in LAUNCH; engine done rises in RUN cycle done_at; returns in the IDLE cycle after FINISH.
    task automatic run_phase(input logic [1:0] mode, input int n_writes, input int done_at,
                             input logic force3);
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            d0;
        d0 = done_seen;
        quiet_engines();
        eng_done[mode] = 1'b1;
        tick();
        for (int c = 1; c <= done_at; c++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0 || fsm_state !== RUN) begin
                n_fail++;
                $display("FAIL run_status c=%0d: busy=%b done=%b ready=%b state=%0d, required 1 0 0 RUN",
                         c, busy, done, cmd_ready, fsm_state);
            end
            if (c == 1) begin
                n_checks++;
                if (eng_rst !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL launch_length: eng_rst=%b in first RUN cycle, required 0000", eng_rst);
                end
            end
            drive_noise(mode);
            if (force3) begin
                eng_wren[3]            = 1'b1;
                eng_wraddr[3*AW +: AW] = AW'(5);
            end
            eng_done[mode] = (c == 1) || (c == done_at);
            a = AW'($urandom);
            d = 8'($urandom);
            eng_wraddr[int'(mode)*AW +: AW] = a;
            eng_wrdata[int'(mode)*8 +: 8]   = d;
            eng_wren[mode] = (c <= n_writes) || (c == done_at);
            if (c <= n_writes) exp_q.push_back({a, d});
            tick();
        end
        quiet_engines();
        n_checks++;
        if (fsm_state !== FINISH || done !== 1'b1 || ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL finish: state=%0d done=%b wren=%b, required FINISH done=1 wren=0",
                     fsm_state, done, ram_wren);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_finish: ready=%b done=%b busy=%b, required 1 0 0", cmd_ready, done, busy);
        end
        n_checks++;
        if (done_seen != d0 + 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL job_end: done pulses=%0d pending writes=%0d, required 1 and 0",
                     done_seen - d0, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_zoom  = 1'b0;
        quiet_engines();
        repeat (3) tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || fsm_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_status: ready=%b busy=%b done=%b err=%b state=%0d, required 1 0 0 0 IDLE",
                     cmd_ready, busy, done, err, fsm_state);
        end
        n_checks++;
        if (cur_mode !== 2'd0 || eng_zoom !== 1'b0 || eng_rst !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_engine: mode=%0d zoom=%b eng_rst=%b, required 0 0 1111",
                     cur_mode, eng_zoom, eng_rst);
        end
        n_checks++;
        if (ram_wraddr !== '0 || ram_data !== 8'h00 || ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ram: addr=%0d data=%02h wren=%b, required 0 00 0", ram_wraddr, ram_data, ram_wren);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (eng_rst !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_release_hold: eng_rst=%b before first clk, required 1111", eng_rst);
        end
        tick();
        n_checks++;
        if (eng_rst !== 4'b0000 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: eng_rst=%b ready=%b, required 0000 1", eng_rst, cmd_ready);
        end
    endtask

    task automatic test_clear_launch();
        send_cmd(MODE_REPLICATE, 1'b1);
        after_accept(MODE_REPLICATE, 1'b1);
        run_phase(MODE_REPLICATE, 6, 10, 1'b0);
    endtask

    task automatic test_done_pulse();
        send_cmd(MODE_NEAREST, 1'b0);
        after_accept(MODE_NEAREST, 1'b0);
        run_phase(MODE_NEAREST, 3, 50, 1'b0);
    endtask

    task automatic test_unselected_ignored();
        send_cmd(MODE_DECIMATE, 1'b1);
        after_accept(MODE_DECIMATE, 1'b1);
        run_phase(MODE_DECIMATE, 0, 12, 1'b1);
    endtask

    task automatic test_timeout();
        int d0;
        send_cmd(MODE_BLOCKAVG, 1'b0);
        after_accept(MODE_BLOCKAVG, 1'b0);
        d0 = done_seen;
        quiet_engines();
        tick();
        for (int c = 1; c <= TMO; c++) begin
            n_checks++;
            if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_run c=%0d: busy=%b err=%b done=%b, required 1 0 0", c, busy, err, done);
            end
            drive_noise(MODE_BLOCKAVG);
            eng_done[3] = 1'b0;
            eng_wren[3] = 1'b0;
            tick();
        end
        quiet_engines();
        n_checks++;
        if (fsm_state !== IDLE || err !== 1'b1 || eng_rst !== 4'b1000 || done_seen != d0) begin
            n_fail++;
            $display("FAIL timeout_abort: state=%0d err=%b eng_rst=%b dones=%0d, required IDLE 1 1000 0",
                     fsm_state, err, eng_rst, done_seen - d0);
        end
        tick();
        n_checks++;
        if (eng_rst !== 4'b0000 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: eng_rst=%b err=%b, required 0000 1", eng_rst, err);
        end
        send_cmd(MODE_DECIMATE, 1'b0);
        after_accept(MODE_DECIMATE, 1'b0);
        run_phase(MODE_DECIMATE, 2, 6, 1'b0);
    endtask

    task automatic test_held_off();
        send_cmd(MODE_NEAREST, 1'b1);
        after_accept(MODE_NEAREST, 1'b1);
        cmd_valid = 1'b1;
        cmd_mode  = MODE_DECIMATE;
        cmd_zoom  = 1'b0;
        run_phase(MODE_NEAREST, 4, 9, 1'b0);
        n_checks++;
        if (cur_mode !== MODE_NEAREST) begin
            n_fail++;
            $display("FAIL held_mode_early: cur_mode=%0d, required 2", cur_mode);
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (cur_mode !== MODE_DECIMATE || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_accept: cur_mode=%0d busy=%b, required 1 1", cur_mode, busy);
        end
        after_accept(MODE_DECIMATE, 1'b0);
        run_phase(MODE_DECIMATE, 1, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] m;
        logic       z;
        int         nw;
        int         da;
        for (int j = 0; j < 6; j++) begin
            m  = 2'($urandom_range(0, 3));
            z  = 1'($urandom_range(0, 1));
            nw = $urandom_range(0, 6);
            da = nw + $urandom_range(2, 12);
            send_cmd(m, z);
            after_accept(m, z);
            run_phase(m, nw, da, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_seen;
`ifdef SCALE_SCHED_CLEAR_EN
        send_cmd(MODE_REPLICATE, 1'b1);
        for (int i = 0; i < 40; i++) exp_q.push_back({AW'(i), BG});
        repeat (40) tick();
        n_checks++;
        if (ram_wraddr !== AW'(40) || ram_wren !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear_pos: addr=%0d wren=%b, required 40 1", ram_wraddr, ram_wren);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ram_wren !== 1'b0 || fsm_state !== IDLE || busy !== 1'b0 || eng_rst !== 4'b1111) begin
            n_fail++;
            $display("FAIL mid_clear_reset: wren=%b state=%0d busy=%b eng_rst=%b, required 0 IDLE 0 1111",
                     ram_wren, fsm_state, busy, eng_rst);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
`endif
        send_cmd(MODE_NEAREST, 1'b0);
        after_accept(MODE_NEAREST, 1'b0);
        quiet_engines();
        tick();
        for (int c = 1; c <= 4; c++) begin
            logic [AW-1:0] a;
            logic [7:0]    d;
            a = AW'($urandom);
            d = 8'($urandom);
            eng_wraddr[2*AW +: AW] = a;
            eng_wrdata[2*8 +: 8]   = d;
            eng_wren[2] = (c != 3);
            if (c <= 2) exp_q.push_back({a, d});
            tick();
        end
        reset = 1'b1;
        quiet_engines();
        #1;
        n_checks++;
        if (ram_wren !== 1'b0 || fsm_state !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: wren=%b state=%0d busy=%b, required 0 IDLE 0", ram_wren, fsm_state, busy);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (done_seen != d0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_effects: done pulses=%0d pending writes=%0d, required 0 0",
                     done_seen - d0, exp_q.size());
        end
        send_cmd(MODE_BLOCKAVG, 1'b1);
        after_accept(MODE_BLOCKAVG, 1'b1);
        run_phase(MODE_BLOCKAVG, 2, 5, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clear_launch();
        test_done_pulse();
        test_unselected_ignored();
        test_timeout();
        test_held_off();
        test_back_to_back();
        test_reset_mid();
        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d writes never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
